lcd_arbiter: RTL and testbench

LCD_ARBITER -- requirements
Module: lcd_arbiter

---
 rtl/lcd_arbiter_pkg.sv | 30 +++
 rtl/lcd_rr_arbiter.sv | 10 +
 rtl/lcd_arbiter.sv | 112 +++++++++++
 tb/tb_lcd_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_arbiter_pkg.sv
// lcd_arbiter_pkg: shared states, init sequence and LCD command constants
package lcd_arbiter_pkg;
  typedef enum logic [2:0] {
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_LINE_ISSUE,
    S_LINE_WAIT
  } state_t;
  localparam logic [8:0] INIT_FUNC     = 9'h038;
  localparam logic [8:0] INIT_DISP     = 9'h00C;
  localparam logic [8:0] INIT_CLEAR    = 9'h001;
  localparam logic [8:0] INIT_ENTRY    = 9'h006;
  localparam logic [8:0] INIT_HOME     = 9'h080;
  localparam logic [2:0] INIT_LAST     = 3'd4;
  localparam logic [8:0] CMD_CLEAR     = 9'h001;
  localparam logic [8:0] CMD_HOME      = 9'h002;
  localparam logic [8:0] CMD_LINE_BASE = 9'h080;
  function automatic logic [8:0] init_cmd(input logic [2:0] idx);
    return idx == 3'd0 ? INIT_FUNC :
           idx == 3'd1 ? INIT_DISP :
           idx == 3'd2 ? INIT_CLEAR :
           idx == 3'd3 ? INIT_ENTRY : INIT_HOME;
  endfunction
  function automatic logic [8:0] line_cmd(input logic line);
    return CMD_LINE_BASE | {2'b00, ~line, 6'h00};
  endfunction
endpackage

// File: rtl/lcd_rr_arbiter.sv
// lcd_rr_arbiter: two-way round-robin choice, pointer is the favoured requester
module lcd_rr_arbiter (
  input  logic [1:0] valid,
  input  logic [1:0] pointer,
  input  logic       enable,
  output logic [1:0] grant
);
  // a lone request wins outright; a tie goes to the pointer's requester
  always_comb grant = !enable ? 2'b00 : valid == 2'b11 ? pointer : valid;
endmodule

// File: rtl/lcd_arbiter.sv
// lcd_arbiter: LCD init sequencer plus two-requester arbiter with cursor tracking
module lcd_arbiter
  import lcd_arbiter_pkg::*;
#(
  parameter int NUM_COLS = 16,
  parameter int NUM_REQ  = 2
) (
  input  logic                    Clock_50,
  input  logic                    Reset,
  input  logic [NUM_REQ-1:0]      Req_valid,
  input  logic [NUM_REQ-1:0][8:0] Req_instruction,
  output logic [NUM_REQ-1:0]      Req_ack,
  output logic                    Init_done,
  output logic                    LCD_start,
  output logic [8:0]              LCD_instruction,
  input  logic                    LCD_done,
  output logic                    LCD_line,
  output logic [3:0]              LCD_position
);
  localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);
  state_t     state;
  logic [2:0] init_idx;
  logic [1:0] rr_ptr;
  logic [1:0] owner;
  logic [1:0] grant;
  logic       done_ok;
  logic       arb_en;
  // done is only trusted once the start pulse has dropped; no grant in an ack cycle
  always_comb begin
    done_ok = !LCD_start && LCD_done;
    arb_en  = state == S_IDLE && Req_ack == '0;
  end
  lcd_rr_arbiter u_rr (
    .valid  (Req_valid),
    .pointer(rr_ptr),
    .enable (arb_en),
    .grant  (grant)
  );
  // sequencer: init, arbitration, transfer, ack, cursor tracking and line wrap
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state           <= S_INIT_ISSUE;
      init_idx        <= 3'd0;
      Init_done       <= 1'b0;
      LCD_start       <= 1'b0;
      LCD_instruction <= 9'h000;
      Req_ack         <= '0;
      LCD_line        <= 1'b0;
      LCD_position    <= 4'd0;
      rr_ptr          <= 2'b01;
      owner           <= 2'b00;
    end else begin
      LCD_start <= 1'b0;
      Req_ack   <= '0;
      case (state)
        S_INIT_ISSUE: begin
          LCD_instruction <= init_cmd(init_idx);
          LCD_start       <= 1'b1;
          state           <= S_INIT_WAIT;
        end
        S_INIT_WAIT: if (done_ok) begin
          if (init_idx == INIT_LAST) begin
            Init_done    <= 1'b1;
            LCD_line     <= 1'b0;
            LCD_position <= 4'd0;
            state        <= S_IDLE;
          end else begin
            init_idx <= init_idx + 3'd1;
            state    <= S_INIT_ISSUE;
          end
        end
        S_IDLE: if (grant != 2'b00) begin
          LCD_instruction <= grant[1] ? Req_instruction[1] : Req_instruction[0];
          LCD_start       <= 1'b1;
          owner           <= grant;
          rr_ptr          <= {grant[0], grant[1]};
          state           <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (done_ok) begin
          Req_ack <= owner;
          if (LCD_instruction[8]) begin
            if (LCD_position == LAST_COL) begin
              LCD_position <= 4'd0;
              state        <= S_LINE_ISSUE;
            end else begin
              LCD_position <= LCD_position + 4'd1;
              state        <= S_IDLE;
            end
          end else begin
            if (LCD_instruction[7]) begin
              LCD_line     <= LCD_instruction[6];
              LCD_position <= LCD_instruction[3:0];
            end else if (LCD_instruction == CMD_CLEAR || LCD_instruction == CMD_HOME) begin
              LCD_line     <= 1'b0;
              LCD_position <= 4'd0;
            end
            state <= S_IDLE;
          end
        end
        S_LINE_ISSUE: begin
          LCD_instruction <= line_cmd(LCD_line);
          LCD_start       <= 1'b1;
          LCD_line        <= ~LCD_line;
          state           <= S_LINE_WAIT;
        end
        S_LINE_WAIT: if (done_ok) state <= S_IDLE;
        default: state <= S_INIT_ISSUE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_arbiter.sv
// tb_lcd_arbiter: randomized and directed checks against a transaction-level model
module tb_lcd_arbiter;
  localparam int COLS = 16;
  localparam int K_INIT = 0, K_REQ = 1, K_LINE = 2;
  localparam logic [8:0] INIT_SEQ [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
  logic            Clock_50 = 1'b0;
  logic            Reset = 1'b1;
  logic [1:0]      Req_valid = 2'b00;
  logic [1:0][8:0] Req_instruction = '0;
  logic [1:0]      Req_ack;
  logic            Init_done, LCD_start, LCD_line;
  logic [8:0]      LCD_instruction;
  logic            LCD_done = 1'b0;
  logic [3:0]      LCD_position;
  int n_checks = 0, n_errors = 0;
  lcd_arbiter #(.NUM_COLS(COLS), .NUM_REQ(2)) dut (
    .Clock_50(Clock_50), .Reset(Reset), .Req_valid(Req_valid),
    .Req_instruction(Req_instruction), .Req_ack(Req_ack), .Init_done(Init_done),
    .LCD_start(LCD_start), .LCD_instruction(LCD_instruction), .LCD_done(LCD_done),
    .LCD_line(LCD_line), .LCD_position(LCD_position)
  );
  always #5 Clock_50 = ~Clock_50;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // LCD controller: done drops on start and rises a few cycles later
  int  dcnt = 0;
  bit  rnd_lat = 0;
  always @(posedge Clock_50) begin
    if (LCD_start === 1'b1) begin
      LCD_done <= 1'b0;
      dcnt <= rnd_lat ? $urandom_range(1, 4) : 2;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) LCD_done <= 1'b1;
    end
  end
  // requesters: raise valid for the queue head, hold until ack
  logic [8:0] req_q [2][$];
  logic [1:0] drv_en = 2'b11;
  int gap [2] = '{0, 0};
  int gap_max = 0;
  always @(posedge Clock_50) begin
    #1;
    for (int i = 0; i < 2; i++) if (drv_en[i]) begin
      if (Req_valid[i] && Req_ack[i] === 1'b1) begin
        Req_valid[i] = 1'b0;
        void'(req_q[i].pop_front());
        gap[i] = $urandom_range(0, gap_max);
      end else if (!Req_valid[i] && req_q[i].size() > 0) begin
        if (gap[i] > 0) gap[i]--;
        else begin
          Req_instruction[i] = req_q[i][0];
          Req_valid[i] = 1'b1;
        end
      end
    end
  end
  // reference model: schedules of issues, completions and grant windows
  bit         m_valid = 0, inflight = 0, issue_line = 0, was_start;
  logic       m_start = 0, m_init = 0, m_line = 0;
  logic [8:0] m_instr = 0, issue_val = 0;
  logic [1:0] m_ack = 0;
  int         m_pos = 0, m_last = 1, owner = 0, kind = K_INIT, init_n = 0, issue_cnt = 0, g;
  longint     cyc = 0, grant_at = -1;
  logic [8:0] start_log [$];
  always @(negedge Clock_50) begin
    if (m_valid) begin
      chk("lcd_start", 32'(LCD_start), 32'(m_start));
      chk("lcd_instruction", 32'(LCD_instruction), 32'(m_instr));
      chk("req_ack", 32'(Req_ack), 32'(m_ack));
      chk("init_done", 32'(Init_done), 32'(m_init));
      chk("lcd_line", 32'(LCD_line), 32'(m_line));
      chk("lcd_position", 32'(LCD_position), 32'(m_pos));
      if (LCD_start === 1'b1) start_log.push_back(LCD_instruction);
    end
    if (Reset) begin
      m_valid = 1; m_start = 0; m_instr = 0; m_ack = 0; m_init = 0; m_line = 0; m_pos = 0;
      m_last = 1; kind = K_INIT; init_n = 0; issue_val = INIT_SEQ[0]; issue_line = 0;
      issue_cnt = 1; inflight = 0; grant_at = -1;
      start_log.delete();
    end else if (m_valid) begin
      was_start = m_start;
      m_start = 0;
      m_ack = 0;
      if (issue_cnt > 0) begin
        issue_cnt--;
        if (issue_cnt == 0) begin
          m_start = 1; m_instr = issue_val; inflight = 1;
          if (issue_line) m_line = ~m_line;
        end
      end else if (inflight && !was_start && LCD_done) begin
        inflight = 0;
        if (kind == K_INIT) begin
          if (init_n == 4) begin
            m_init = 1; m_line = 0; m_pos = 0; grant_at = cyc + 1;
          end else begin
            init_n++; issue_val = INIT_SEQ[init_n]; issue_line = 0; issue_cnt = 1;
          end
        end else if (kind == K_REQ) begin
          m_ack[owner] = 1'b1;
          if (m_instr[8]) begin
            if (m_pos == COLS - 1) begin
              m_pos = 0; issue_val = {2'b01, ~m_line, 6'h00}; issue_line = 1;
              issue_cnt = 1; kind = K_LINE;
            end else begin
              m_pos++; grant_at = cyc + 2;
            end
          end else begin
            if (m_instr[7]) begin
              m_line = m_instr[6]; m_pos = int'(m_instr[3:0]);
            end else if (m_instr == 9'h001 || m_instr == 9'h002) begin
              m_line = 0; m_pos = 0;
            end
            grant_at = cyc + 2;
          end
        end else grant_at = cyc + 1;
      end else if (grant_at >= 0 && cyc >= grant_at && Req_valid != 2'b00) begin
        g = (Req_valid == 2'b11) ? 1 - m_last : (Req_valid[1] ? 1 : 0);
        m_last = g; owner = g; kind = K_REQ; m_start = 1; m_instr = Req_instruction[g];
        inflight = 1; grant_at = -1;
      end
    end
    cyc++;
  end
  logic [1:0] ack_seen [$];
  task automatic wait_ack(input int n, input int budget, input string name);
    int seen = 0, c = 0;
    while (seen < n && c < budget) begin
      @(negedge Clock_50);
      c++;
      if (Req_ack !== 2'b00) begin seen++; ack_seen.push_back(Req_ack); end
    end
    if (seen < n) chk(name, 32'(seen), 32'(n));
  endtask
  task automatic wait_start(input int budget, input string name);
    int c = 0;
    do begin @(negedge Clock_50); c++; end while (LCD_start !== 1'b1 && c < budget);
    if (LCD_start !== 1'b1) chk(name, 32'(LCD_start), 32'd1);
  endtask
  function automatic logic [8:0] rand_instr();
    int k = $urandom_range(0, 9);
    return k < 6 ? {1'b1, 8'($urandom)} :
           k == 6 ? {2'b01, 1'($urandom), 2'b00, 4'($urandom)} :
           k == 7 ? 9'h001 : k == 8 ? 9'h002 : {2'b00, 7'($urandom)};
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int c, acks, a0, base;
    req_q[0].push_back(9'h141);
    req_q[1].push_back(9'h142);
    repeat (3) @(posedge Clock_50);
    #1 Reset = 1'b0;
    c = 0; acks = 0;
    while (Init_done !== 1'b1 && c < 400) begin
      @(negedge Clock_50); c++;
      if (Req_ack !== 2'b00) acks++;
    end
    chk("init_done_reached", 32'(Init_done), 32'd1);
    chk("init_start_count", 32'(start_log.size()), 32'd5);
    for (int k = 0; k < 5; k++) if (k < start_log.size()) chk("init_seq", 32'(start_log[k]), 32'(INIT_SEQ[k]));
    chk("init_no_ack", 32'(acks), 32'd0);
    ack_seen.delete();
    wait_ack(2, 100, "rr_ack_timeout");
    if (ack_seen.size() == 2) begin
      chk("rr_ack_first", 32'(ack_seen[0]), 32'h1);
      chk("rr_ack_second", 32'(ack_seen[1]), 32'h2);
    end
    if (start_log.size() >= 7) begin
      chk("rr_issue_first", 32'(start_log[5]), 32'h141);
      chk("rr_issue_second", 32'(start_log[6]), 32'h142);
    end
    req_q[0].push_back(9'h001);
    for (int k = 0; k < 16; k++) req_q[0].push_back(9'h130 + 9'(k));
    req_q[0].push_back(9'h141);
    wait_ack(17, 600, "wrap_ack_timeout");
    wait_start(50, "wrap_line_start_timeout");
    chk("wrap_line_cmd", 32'(LCD_instruction), 32'h0C0);
    chk("wrap_line", 32'(LCD_line), 32'd1);
    chk("wrap_position", 32'(LCD_position), 32'd0);
    wait_ack(1, 100, "wrap_next_ack_timeout");
    base = start_log.size();
    if (base >= 3) begin
      chk("wrap_order_last_char", 32'(start_log[base-3]), 32'h13F);
      chk("wrap_order_line_cmd", 32'(start_log[base-2]), 32'h0C0);
      chk("wrap_order_next_char", 32'(start_log[base-1]), 32'h141);
    end
    chk("wrap_next_position", 32'(LCD_position), 32'd1);
    req_q[0].push_back(9'h0C5);
    wait_ack(1, 100, "cursor_ack_timeout");
    chk("cursor_line", 32'(LCD_line), 32'd1);
    chk("cursor_position", 32'(LCD_position), 32'd5);
    req_q[0].push_back(9'h001);
    wait_ack(1, 100, "clear_ack_timeout");
    chk("clear_line", 32'(LCD_line), 32'd0);
    chk("clear_position", 32'(LCD_position), 32'd0);
    req_q[0].push_back(9'h150);
    c = 0;
    do begin @(negedge Clock_50); c++; end
      while (!(LCD_start === 1'b1 && LCD_instruction == 9'h150) && c < 100);
    chk("reset_char_started", 32'(LCD_instruction), 32'h150);
    @(posedge Clock_50); #1 Reset = 1'b1;
    @(posedge Clock_50); #1 Reset = 1'b0;
    c = 0; acks = 0;
    do begin
      @(negedge Clock_50); c++;
      if (Req_ack !== 2'b00) acks++;
    end while (LCD_start !== 1'b1 && c < 50);
    chk("reset_restart_cmd", 32'(LCD_instruction), 32'h038);
    chk("reset_init_done_low", 32'(Init_done), 32'd0);
    chk("reset_no_ack", 32'(acks), 32'd0);
    wait_ack(1, 400, "reset_reissue_ack_timeout");
    repeat (3) @(posedge Clock_50);
    drv_en[0] = 1'b0;
    #1 Req_instruction[0] = 9'h003;
    Req_valid[0] = 1'b1;
    wait_start(50, "drop_start_timeout");
    chk("drop_issued", 32'(LCD_instruction), 32'h003);
    @(posedge Clock_50); #1 Req_valid[0] = 1'b0;
    a0 = 0;
    repeat (20) begin @(negedge Clock_50); if (Req_ack === 2'b01) a0++; end
    chk("drop_single_ack", 32'(a0), 32'd1);
    drv_en[0] = 1'b1;
    gap_max = 3;
    rnd_lat = 1;
    for (int k = 0; k < 150; k++) begin
      req_q[0].push_back(rand_instr());
      req_q[1].push_back(rand_instr());
    end
    c = 0;
    while ((req_q[0].size() > 0 || req_q[1].size() > 0 || Req_valid != 2'b00) && c < 20000) begin
      @(negedge Clock_50); c++;
    end
    chk("random_drained", 32'(req_q[0].size() + req_q[1].size()), 32'd0);
    repeat (10) @(negedge Clock_50);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
